music_box_state_make_recording: RTL

//  Record stage of the MusicBox UI; upstream producer for the playback stage.

---
 rtl/music_box_state_make_recording_if.sv | 27 ++
 rtl/music_box_state_make_recording.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/music_box_state_make_recording_if.sv
// Record-stage bundle: controller/keyboard inputs in, recording-memory write port and status out.
interface music_box_state_make_recording_if #(
   parameter int NOTE_W = 5,
   parameter int DUR_W  = 13,
   parameter int ADDR_W = 8
);
   logic [4:0]              currentState;
   logic [NOTE_W-1:0]       noteIn;
   logic                    stopRecording;
   logic                    mem_wr_en;
   logic [ADDR_W-1:0]       mem_wr_addr;
   logic [NOTE_W+DUR_W-1:0] mem_wr_data;
   logic [ADDR_W:0]         recordingLength;
   logic                    stateComplete;
   logic [31:0]             debugString;

   // master: the record stage, which drives the memory write port
   modport master (
      input  currentState, noteIn, stopRecording,
      output mem_wr_en, mem_wr_addr, mem_wr_data, recordingLength, stateComplete, debugString
   );

   modport slave (
      output currentState, noteIn, stopRecording,
      input  mem_wr_en, mem_wr_addr, mem_wr_data, recordingLength, stateComplete, debugString
   );
endinterface

// File: rtl/music_box_state_make_recording.sv
// MusicBox record stage: run-length encodes the sampled note bus into {note, duration} memory entries.
// Tick-to-write 1 cycle; last tick or stop to stateComplete within 3 cycles; no backpressure on the write port.
module music_box_state_make_recording #(
   parameter logic [4:0] STATE_ID  = 5'd2,
   parameter int         CLK_HZ    = 50_000_000,
   parameter int         TICK_HZ   = 1000,
   parameter int         MAX_TICKS = 5000,
   parameter int         NOTE_W    = 5,
   parameter int         DUR_W     = 13,
   parameter int         ADDR_W    = 8
) (
   input  logic clock_50Mhz,
   input  logic reset,
   music_box_state_make_recording_if.master rec
);
   localparam int PS_RAW = $clog2(CLK_HZ / TICK_HZ);
   localparam int PS_W   = (PS_RAW < 1) ? 1 : PS_RAW;
   localparam int TT_RAW = $clog2(MAX_TICKS + 1);
   localparam int TT_W   = (TT_RAW > 13) ? TT_RAW : 13;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [PS_W-1:0]   PS_TC    = PS_W'(CLK_HZ / TICK_HZ - 1);
   localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);
   localparam logic [TT_W-1:0]   TT_LAST  = TT_W'(MAX_TICKS - 1);
   localparam logic [TT_W-1:0]   TT_ONE   = TT_W'(1);
   localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
   localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
   localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECORD = 2'd1,
      S_FLUSH  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                  r_fsm;
   logic [PS_W-1:0]         r_presc;
   logic [TT_W-1:0]         r_total;
   logic [ADDR_W:0]         r_count;
   logic [NOTE_W-1:0]       r_run_note;
   logic [DUR_W-1:0]        r_run_len;
   logic                    r_wr_en;
   logic [ADDR_W-1:0]       r_wr_addr;
   logic [NOTE_W+DUR_W-1:0] r_wr_data;
   logic [ADDR_W:0]         r_rec_len;
   logic                    r_complete;

   logic w_sel, w_tick, w_extend, w_emit, w_last, w_max;

   assign w_sel    = (rec.currentState == STATE_ID);
   assign w_tick   = (r_fsm == S_RECORD) && (r_presc == PS_TC);
   assign w_extend = (rec.noteIn == r_run_note) && (r_run_len != DUR_MAX);
   assign w_emit   = w_tick && (r_run_len != '0) && !w_extend;
   assign w_last   = (r_count == CNT_LAST);
   assign w_max    = w_tick && (r_total == TT_LAST);

   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         r_fsm      <= S_IDLE;
         r_presc    <= '0;
         r_total    <= '0;
         r_count    <= '0;
         r_run_note <= '0;
         r_run_len  <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rec_len  <= '0;
         r_complete <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               r_presc <= '0;
               if (w_sel) begin
                  r_fsm      <= S_RECORD;
                  r_total    <= '0;
                  r_count    <= '0;
                  r_run_len  <= '0;
                  r_rec_len  <= '0;
                  r_complete <= 1'b0;
               end
            end
            S_RECORD: begin
               if (!w_sel) begin
                  r_fsm     <= S_IDLE;
                  r_presc   <= '0;
                  r_rec_len <= '0;
               end else begin
                  r_presc <= w_tick ? '0 : r_presc + PS_ONE;
                  if (w_tick) begin
                     r_total <= r_total + TT_ONE;
                     if (r_run_len != '0 && w_extend) begin
                        r_run_len <= r_run_len + DUR_ONE;
                     end else begin
                        r_run_note <= rec.noteIn;
                        r_run_len  <= DUR_ONE;
                     end
                  end
                  if (w_emit) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_count[ADDR_W-1:0];
                     r_wr_data <= {r_run_note, r_run_len};
                     r_count   <= r_count + CNT_ONE;
                  end
                  // A write into the last slot ends the recording; the run begun this tick has nowhere to go.
                  if (w_emit && w_last) begin
                     r_fsm <= S_DONE;
                  end else if (rec.stopRecording || w_max) begin
                     r_fsm <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               r_presc <= '0;
               if (!w_sel) begin
                  r_fsm     <= S_IDLE;
                  r_rec_len <= '0;
               end else begin
                  r_fsm <= S_DONE;
                  if (r_run_len != '0) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_count[ADDR_W-1:0];
                     r_wr_data <= {r_run_note, r_run_len};
                     r_count   <= r_count + CNT_ONE;
                     r_run_len <= '0;
                  end
               end
            end
            S_DONE: begin
               r_presc    <= '0;
               r_rec_len  <= r_count;
               r_complete <= w_sel;
               if (!w_sel) begin
                  r_fsm <= S_IDLE;
               end
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign rec.mem_wr_en       = r_wr_en;
   assign rec.mem_wr_addr     = r_wr_addr;
   assign rec.mem_wr_data     = r_wr_data;
   assign rec.recordingLength = r_rec_len;
   assign rec.stateComplete   = r_complete;
   assign rec.debugString     = {14'b0, r_fsm, 3'b0, r_total[12:0]};
endmodule
